seq_tracker: RTL
================

Name: seq_tracker

Overview:
- Receive-side companion to the team's 4-bit up/down code-sequence generator.
- Watches a stream of 4-bit codes, locks onto the fixed code ring, and infers direction: forward (S=0) or reverse (S=1).
- While locked, flags every out-of-sequence code.
- Sits between the generator (or the board switches) and the display/status logic. Pure observer: no backpressure.

Parameters:
- MAX_MISS, 2, consecutive mismatches in LOCKED that force a return to HUNT (1..7)
- CNT_W, 8, width of the saturating match counter

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Valid  in  1  Code is sampled on this cycle
- Code  in  4  incoming code (Y4..Y1 order, MSB = Y4)
- Locked  out  1  tracker is in LOCKED
- Dir  out  1  inferred direction; 0 = forward, 1 = reverse; meaningful only when Locked=1
- Expected  out  4  next code predicted while locked; 0 otherwise
- Err  out  1  one-cycle pulse on a mismatch while locked
- MatchCnt  out  CNT_W  number of matched codes since lock, saturating

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: state=HUNT, Locked=0, Dir=0, Expected=0, Err=0, MatchCnt=0, index=0, miss=0.
- Reset asserted mid-operation overrides any Valid on that cycle.
- Latency: all outputs are registered. Each reflects the Valid sample taken on the previous rising edge.
- Valid=0 cycles: hold all state. Err=0.
- Ring: SEQ[0..7] = 0001,0011,1001,0111,0010,0110,1000,0100 (forward order).
  - Index arithmetic is mod 8: 7+1 wraps to 0, 0-1 wraps to 7.
  - Any code not in SEQ (e.g. 0000, 0101, 1111) is "foreign".
- State machine:
  - HUNT:
    - Valid with an in-ring code: store its index, go to CONFIRM.
    - Foreign code: stay in HUNT.
    - Err never asserts in HUNT.
  - CONFIRM:
    - Valid code == SEQ[idx+1]: Dir=0, idx=idx+1, go to LOCKED, MatchCnt=1.
    - Valid code == SEQ[idx-1]: Dir=1, idx=idx-1, go to LOCKED, MatchCnt=1.
    - Both conditions cannot hold (ring length 8, distinct codes). Forward is checked first regardless.
    - Other in-ring code (including a repeat of the same code): re-anchor idx to it, stay in CONFIRM.
    - Foreign code: go to HUNT.
  - LOCKED:
    - Expected = SEQ[idx+1] if Dir=0, else SEQ[idx-1].
    - Valid code == Expected: idx advances, miss=0, MatchCnt++ (saturating at 2^CNT_W-1), Err=0.
    - Mismatch: Err=1 for one cycle, miss++. idx still advances (flywheel), Dir unchanged.
    - Mismatch that brings miss to MAX_MISS: go to HUNT, Locked=0, Expected=0, MatchCnt=0, miss=0. Err still pulses on that cycle.
- Direction reversal while locked: shows up as mismatches. The tracker relocks through HUNT/CONFIRM with the new Dir. It never flips Dir in place.
- Back-to-back Valid every cycle is supported with no bubbles.

Decomposition:
- Package seq_pkg holds:
  - SEQ_LEN=8 and the SEQ code array
  - state encoding HUNT/CONFIRM/LOCKED
  - DIR_FWD/DIR_REV constants
- One sub-module, seq_lookup: combinational code -> {hit, index[2:0]}. The generator's testbench reuses it as a reference model.
- FSM and counters live in seq_tracker.

Test Plan:
- Reset, then Valid codes 0001,0011,1001,0111 → Locked=1 after the 2nd code's edge, Dir=0, Expected=0111 then 0010, MatchCnt=3, Err never asserts.
- Reverse stream 0100,1000,0110,0010 → Locked=1, Dir=1, Expected after last = 0111, MatchCnt=3.
- Locked forward at 0100, next code 0001 → idx wraps 7→0, match, Expected=0011. MatchCnt saturates at 255 after 300 matches.
- Locked forward, inject 0101 once then correct flywheel code → single Err pulse, stays locked. Two consecutive bad codes → two Err pulses, Locked=0, MatchCnt=0 on the second.
- HUNT with foreign 0000,1111 then 0001,0001,0011 → no Err; CONFIRM re-anchors on the repeated 0001; locks Dir=0 on 0011.
- Assert Reset while locked with Valid=1 on the same cycle → next cycle all outputs at reset values, sample ignored.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared definitions for the code-sequence tracker: the
//                8-entry forward code ring, tracker state encoding and
//                direction constants, plus a ring-lookup helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int SEQ_LEN = 8;

    // Forward ring, entry 0 in the least-significant nibble:
    // 0001,0011,1001,0111,0010,0110,1000,0100
    localparam logic [4*SEQ_LEN-1:0] SEQ_TABLE = {
        4'b0100, 4'b1000, 4'b0110, 4'b0010,
        4'b0111, 4'b1001, 4'b0011, 4'b0001
    };

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Ring entry at a 3-bit index; mod-8 wrap comes for free from the width.
    function automatic logic [3:0] seq_code(input logic [2:0] idx);
        return SEQ_TABLE[{idx, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : seq_lookup
//  Description : Combinational reverse lookup of a 4-bit code in the ring.
//  Ports       : code_i  - code to look up
//                hit_o   - code is a member of the ring
//                index_o - ring position of the code (0 when not a member)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_lookup
    import seq_pkg::*;
(
    input  logic [3:0] code_i,
    output logic       hit_o,
    output logic [2:0] index_o
);

    always_comb begin
        hit_o   = 1'b0;
        index_o = 3'd0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (code_i == seq_code(3'(i))) begin
                hit_o   = 1'b1;
                index_o = 3'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : seq_tracker
//  Description : Locks onto the 8-entry code ring, infers the stepping
//                direction and flags out-of-sequence codes while locked.
//                Pure observer, all outputs registered.
//  Ports       : clk_i        - rising-edge clock
//                rst_i        - synchronous active-high reset
//                valid_i      - code_i is sampled this cycle
//                code_i       - incoming code (MSB = Y4)
//                locked_o     - tracker is locked
//                dir_o        - 0 forward, 1 reverse (meaningful when locked)
//                expected_o   - predicted next code while locked, else 0
//                err_o        - one-cycle pulse on a mismatch while locked
//                match_cnt_o  - saturating count of matches since lock
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_tracker
    import seq_pkg::*;
#(
    parameter int MAX_MISS = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       code_i,
    output logic             locked_o,
    output logic             dir_o,
    output logic [3:0]       expected_o,
    output logic             err_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       miss_q, miss_d;
    logic             dir_q, dir_d;
    logic [3:0]       expected_q, expected_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_hit;
    logic [2:0]       w_hit_idx;
    logic [2:0]       w_step_idx;   // flywheel index for this LOCKED sample
    logic [2:0]       w_after_idx;  // entry predicted after w_step_idx
    logic [2:0]       w_miss_inc;

    seq_lookup u_lookup (
        .code_i  (code_i),
        .hit_o   (w_hit),
        .index_o (w_hit_idx)
    );

    assign w_step_idx  = (dir_q == DIR_REV) ? idx_q - 3'd1 : idx_q + 3'd1;
    assign w_after_idx = (dir_q == DIR_REV) ? w_step_idx - 3'd1 : w_step_idx + 3'd1;
    assign w_miss_inc  = miss_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        miss_d     = miss_q;
        dir_d      = dir_q;
        expected_d = expected_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;

        if (valid_i) begin
            case (state_q)
                ST_HUNT: begin
                    if (w_hit) begin
                        idx_d   = w_hit_idx;
                        state_d = ST_CONFIRM;
                    end
                end

                ST_CONFIRM: begin
                    // Forward wins by construction; the two neighbours can never
                    // carry the same code on an 8-entry ring of distinct codes.
                    if (code_i == seq_code(idx_q + 3'd1)) begin
                        dir_d      = DIR_FWD;
                        idx_d      = idx_q + 3'd1;
                        expected_d = seq_code(idx_q + 3'd2);
                        cnt_d      = CNT_W'(1);
                        miss_d     = 3'd0;
                        state_d    = ST_LOCKED;
                    end else if (code_i == seq_code(idx_q - 3'd1)) begin
                        dir_d      = DIR_REV;
                        idx_d      = idx_q - 3'd1;
                        expected_d = seq_code(idx_q - 3'd2);
                        cnt_d      = CNT_W'(1);
                        miss_d     = 3'd0;
                        state_d    = ST_LOCKED;
                    end else if (w_hit) begin
                        idx_d = w_hit_idx;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end

                ST_LOCKED: begin
                    // Index advances on every sample, hit or miss, so a single
                    // corrupted code does not desynchronise the prediction.
                    idx_d      = w_step_idx;
                    expected_d = seq_code(w_after_idx);
                    if (code_i == expected_q) begin
                        miss_d = 3'd0;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                        if (w_miss_inc == 3'(MAX_MISS)) begin
                            state_d    = ST_HUNT;
                            expected_d = 4'd0;
                            cnt_d      = '0;
                            miss_d     = 3'd0;
                        end else begin
                            miss_d = w_miss_inc;
                        end
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_HUNT;
            idx_q      <= 3'd0;
            miss_q     <= 3'd0;
            dir_q      <= DIR_FWD;
            expected_q <= 4'd0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            miss_q     <= miss_d;
            dir_q      <= dir_d;
            expected_q <= expected_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign locked_o    = (state_q == ST_LOCKED);
    assign dir_o       = dir_q;
    assign expected_o  = expected_q;
    assign err_o       = err_q;
    assign match_cnt_o = cnt_q;

endmodule
`default_nettype wire
